i2s_tx_ctrl: RTL and testbench
==============================

// Module: i2s_tx_ctrl
// PURPOSE
//   I2S transmit controller driving io_i2s_lrclk/io_i2s_bclk/io_i2s_data from the SoC clock.
//   Buffers stereo frames written by the CPU-side bus in a small FIFO.
//   Generates BCLK/LRCLK by integer division and schedules one frame load per LRCLK period.
//   Flags underrun and low FIFO level so firmware can refill on interrupt.
// PARAMETERS
//   DEPTH     8   FIFO depth in stereo frames; power of 2, >=2
//   WIDTH     16  bits per channel sample
//   BCLK_DIV  4   clk cycles per BCLK half-period; >=1
// PORTS
//   clk           in   1            system clock; all logic on posedge
//   rst           in   1            synchronous, active-high reset
//   en            in   1            run enable, level-sensitive
//   wr_valid      in   1            frame write request
//   wr_ready      out  1            FIFO can accept; 1 when level != DEPTH
//   wr_data       in   2*WIDTH      {left[WIDTH-1:0], right[WIDTH-1:0]}
//   level         out  clog2(DEPTH)+1  frames currently held
//   irq_half      out  1            level <= DEPTH/2
//   underrun      out  1            1-clk pulse when a frame load finds FIFO empty
//   io_i2s_bclk   out  1            bit clock, period 2*BCLK_DIV clk
//   io_i2s_lrclk  out  1            word select; 0 = left, 1 = right
//   io_i2s_data   out  1            serial data, MSB first, changes on BCLK fall
// BEHAVIOUR
//   Reset: all outputs 0 except wr_ready=1 and irq_half=1; FIFO flushed; state IDLE.
//     Applies mid-frame too; outputs return to reset values at the next clk edge.
//   FIFO: accept on wr_valid&&wr_ready; pop only at frame load; level counts push-minus-pop.
//     Push and pop in the same cycle: level unchanged.
//     Load when FIFO empty: outputs zero frame, pulses underrun; a same-cycle write is still accepted.
//   Divider: div_cnt counts 0..BCLK_DIV-1 in RUN/DRAIN; BCLK toggles when div_cnt==BCLK_DIV-1.
//     A fall event is a toggle while BCLK=1.
//   Slot counter: bit_cnt 0..2*WIDTH-1, updated on each fall event; wraps to 0.
//     LRCLK = (bit_cnt >= WIDTH), registered alongside bit_cnt.
//   Shift register shreg[2*WIDTH-1:0]; io_i2s_data = shreg MSB.
//     On the fall event where bit_cnt becomes 1: load shreg from FIFO head (or zeros); otherwise shift left.
//     Gives the standard I2S one-BCLK delay: left MSB at slot 1, right MSB at slot WIDTH+1.
//     Right LSB lands at slot 0 of the next frame.
//   States:
//     IDLE : BCLK=LRCLK=data=0, counters 0. en=1 -> RUN.
//     RUN  : free-running. If en=0 at the fall event wrapping bit_cnt to 0 -> DRAIN.
//            en=0 elsewhere mid-frame is ignored until that wrap.
//     DRAIN: outputs slot 0 (previous right LSB). At the next fall event -> IDLE, with data/LRCLK forced 0.
//            en=1 during DRAIN -> RUN at that fall event instead; frame loads normally.
//   No frame is popped in DRAIN/IDLE. level/irq_half are valid in all states.
// TESTING
//   1. Reset: hold rst 3 clk -> all outputs 0, wr_ready=1, irq_half=1, level=0.
//   2. WIDTH=16, BCLK_DIV=2: write 32'hA5F0_0F5A, en=1 ->
//      BCLK period 4 clk; LRCLK low 16 BCLK then high 16.
//      Data slots 1..16 = A5F0 MSB-first; slots 17..31 plus next slot 0 = 0F5A.
//   3. Write 8 frames with en=0 -> level=8, wr_ready=0, 9th write dropped.
//      Then en=1 -> level=7 after the first load, irq_half=0 until level<=4.
//   4. en=1 with empty FIFO -> underrun pulses exactly once per 32 BCLK, data stays 0, level stays 0.
//   5. Drop en at slot 10 -> frame completes, slot 0 carries right LSB, then IDLE with BCLK=0.
//      Remaining FIFO contents are not popped.
//   6. Assert rst at slot 20 with level=3 -> next clk: BCLK=LRCLK=data=0, level=0, state IDLE.

Source files
------------

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: frame FIFO, BCLK/LRCLK divider and MSB-first serializer.
// A frame is popped once per LRCLK period, one BCLK after the left-slot boundary.
module i2s_tx_ctrl #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [2*WIDTH-1:0]       wr_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     irq_half,
  output logic                     underrun,
  output logic                     io_i2s_bclk,
  output logic                     io_i2s_lrclk,
  output logic                     io_i2s_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            lrclk_q, lrclk_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic            underrun_q, underrun_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [FW-1:0]   mem_q [DEPTH];

  logic            tick;
  logic            fall;
  logic            load;
  logic            push;
  logic            pop;
  logic [BW-1:0]   bit_nxt;

  assign wr_ready     = (level_q != LW'(DEPTH));
  assign irq_half     = (level_q <= LW'(DEPTH / 2));
  assign level        = level_q;
  assign underrun     = underrun_q;
  assign io_i2s_bclk  = bclk_q;
  assign io_i2s_lrclk = lrclk_q;
  assign io_i2s_data  = shreg_q[FW-1];

  assign push    = wr_valid && wr_ready;
  assign tick    = (state_q != IDLE) && (div_cnt_q == DW'(BCLK_DIV - 1));
  assign fall    = tick && bclk_q;
  assign bit_nxt = (bit_cnt_q == BW'(FW - 1)) ? '0 : bit_cnt_q + BW'(1);
  // DRAIN only reloads when en comes back; bit_nxt is then 1 because DRAIN sits in slot 0
  assign load    = fall && (bit_nxt == BW'(1)) && ((state_q == RUN) || en);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrclk_d    = lrclk_q;
    shreg_d    = shreg_q;
    underrun_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bclk_d    = 1'b0;
        bit_cnt_d = '0;
        lrclk_d   = 1'b0;
        shreg_d   = '0;
        if (en) state_d = RUN;
      end
      default: begin
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
        if (tick) bclk_d = ~bclk_q;
        if (fall) begin
          bit_cnt_d = bit_nxt;
          lrclk_d   = (bit_nxt >= BW'(WIDTH));
          if (load) begin
            pop        = (level_q != '0);
            underrun_d = (level_q == '0);
            shreg_d    = pop ? mem_q[rd_ptr_q] : '0;
          end else begin
            shreg_d = shreg_q << 1;
          end
          if ((state_q == RUN) && (bit_nxt == '0) && !en) state_d = DRAIN;
          if (state_q == DRAIN) begin
            if (en) begin
              state_d = RUN;
            end else begin
              state_d   = IDLE;
              div_cnt_d = '0;
              bclk_d    = 1'b0;
              bit_cnt_d = '0;
              lrclk_d   = 1'b0;
              shreg_d   = '0;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    level_d  = level_q + LW'(push) - LW'(pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrclk_q    <= 1'b0;
      shreg_q    <= '0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrclk_q    <= lrclk_d;
      shreg_q    <= shreg_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage is not reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Self-checking bench for i2s_tx_ctrl: random frames checked cycle by cycle against
// an arithmetic model of the I2S timeline (slot = cycles / (2*BCLK_DIV)).
module tb_i2s_tx_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int DIV   = 2;
  localparam int FW    = 2 * WIDTH;
  localparam int SLOT  = 2 * DIV;
  localparam int FRAME = SLOT * FW;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [FW-1:0] wr_data = '0;
  logic [LW-1:0] level;
  logic          irq_half;
  logic          underrun;
  logic          io_i2s_bclk;
  logic          io_i2s_lrclk;
  logic          io_i2s_data;

  int total = 0;
  int bad = 0;
  logic [FW-1:0] ref_q[$];

  i2s_tx_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .level(level), .irq_half(irq_half), .underrun(underrun),
    .io_i2s_bclk(io_i2s_bclk), .io_i2s_lrclk(io_i2s_lrclk), .io_i2s_data(io_i2s_data)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_q.delete();
  endtask

  task automatic write_frame(input logic [FW-1:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    if (ref_q.size() != DEPTH) ref_q.push_back(d);
  endtask

  // Starts from IDLE: en is raised for edge n=0, dropped from edge drop_n onward.
  task automatic run_check(input string tag, input int ncyc, input int drop_n, input bit wr_mode);
    logic [FW-1:0]   cur;
    logic [FW-1:0]   wd;
    logic [3:0]      exp_w, got_w;
    logic [LW+1:0]   exp_s, got_s;
    int              idle_from, s, lvl;
    bit              en_e, wr_e, ld, acc, exp_ur, e_bclk, e_lr, e_data;
    cur = '0;
    idle_from = NEVER;
    for (int n = 0; n < ncyc; n++) begin
      s = n / SLOT;
      en_e = (n < drop_n);
      ld = (n > 0) && (n % SLOT == 0) && (s % FW == 1) && (n < idle_from);
      wr_e = wr_mode && (ld || ($urandom_range(63) == 0));
      wd = $urandom;
      en = en_e;
      wr_valid = wr_e;
      wr_data = wd;
      @(posedge clk);
      #1;
      acc = wr_e && (ref_q.size() != DEPTH);
      exp_ur = 1'b0;
      if (ld) begin
        if (ref_q.size() == 0) begin
          cur = '0;
          exp_ur = 1'b1;
        end else begin
          cur = ref_q.pop_front();
        end
      end
      if (acc) ref_q.push_back(wd);
      if ((n > 0) && (n % SLOT == 0) && (s % FW == 0) && !en_e && (idle_from > n))
        idle_from = n + SLOT;
      if (n >= idle_from) begin
        e_bclk = 1'b0;
        e_lr = 1'b0;
        e_data = 1'b0;
      end else begin
        e_bclk = ((n / DIV) % 2) == 1;
        e_lr = (s % FW) >= WIDTH;
        e_data = (s == 0) ? 1'b0 : cur[FW - 1 - ((s - 1) % FW)];
      end
      exp_w = {e_bclk, e_lr, e_data, exp_ur};
      got_w = {io_i2s_bclk, io_i2s_lrclk, io_i2s_data, underrun};
      total++;
      if (got_w !== exp_w) begin
        bad++;
        $display("[TB] FAIL %s wave n=%0d {bclk,lrclk,data,underrun} got=%b exp=%b", tag, n, got_w, exp_w);
      end
      lvl = ref_q.size();
      exp_s = {LW'(lvl), lvl != DEPTH, lvl <= DEPTH / 2};
      got_s = {level, wr_ready, irq_half};
      total++;
      if (got_s !== exp_s) begin
        bad++;
        $display("[TB] FAIL %s status n=%0d {level,wr_ready,irq_half} got=%h exp=%h", tag, n, got_s, exp_s);
      end
    end
    en = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({io_i2s_bclk, io_i2s_lrclk, io_i2s_data, underrun} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b exp=0000", {io_i2s_bclk, io_i2s_lrclk, io_i2s_data, underrun});
    end
    total++;
    if ({level, wr_ready, irq_half} !== {LW'(0), 2'b11}) begin
      bad++;
      $display("[TB] FAIL reset_status got=%h exp=%h", {level, wr_ready, irq_half}, {LW'(0), 2'b11});
    end
    rst = 1'b0;
    ref_q.delete();
  endtask

  task automatic test_pattern();
    do_reset();
    write_frame(32'hA5F0_0F5A);
    run_check("pattern", 2 * FRAME + 2 * SLOT, FRAME + SLOT, 1'b0);
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      write_frame($urandom);
      total++;
      if (level !== LW'(ref_q.size())) begin
        bad++;
        $display("[TB] FAIL fill_level i=%0d got=%0d exp=%0d", i, level, ref_q.size());
      end
    end
    total++;
    if ({wr_ready, irq_half} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL full_flags got=%b exp=00", {wr_ready, irq_half});
    end
    run_check("fill", (DEPTH + 1) * FRAME + 4 * SLOT, DEPTH * FRAME + 5, 1'b0);
  endtask

  task automatic test_underrun();
    do_reset();
    run_check("underrun", 3 * FRAME + 2 * SLOT, 2 * FRAME + 3 * SLOT, 1'b0);
  endtask

  task automatic test_drain_stop();
    do_reset();
    for (int i = 0; i < 3; i++) write_frame($urandom);
    run_check("drain", 2 * FRAME, 10 * SLOT, 1'b0);
    total++;
    if (level !== LW'(2)) begin
      bad++;
      $display("[TB] FAIL drain_level got=%0d exp=2", level);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_check("b2b", 5 * FRAME + 2 * SLOT, 4 * FRAME + SLOT, 1'b1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) write_frame($urandom);
    run_check("midrst", 20 * SLOT + 2, NEVER, 1'b0);
    total++;
    if (level !== LW'(3)) begin
      bad++;
      $display("[TB] FAIL midrst_pre_level got=%0d exp=3", level);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({io_i2s_bclk, io_i2s_lrclk, io_i2s_data, level, wr_ready, irq_half} !== {3'b000, LW'(0), 2'b11}) begin
      bad++;
      $display("[TB] FAIL midrst_after got=%h exp=%h",
               {io_i2s_bclk, io_i2s_lrclk, io_i2s_data, level, wr_ready, irq_half}, {3'b000, LW'(0), 2'b11});
    end
    rst = 1'b0;
    ref_q.delete();
    for (int i = 0; i < 3 * SLOT; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({io_i2s_bclk, io_i2s_lrclk, io_i2s_data} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL midrst_idle i=%0d got=%b exp=000", i, {io_i2s_bclk, io_i2s_lrclk, io_i2s_data});
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_fill_drain();
    test_underrun();
    test_drain_stop();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
